key_search_scheduler: RTL and testbench

KEY_SEARCH_SCHEDULER -- requirements
Module: key_search_scheduler

---
 rtl/key_search_scheduler.sv | 173 +++++++++++++++++
 tb/tb_key_search_scheduler.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_scheduler.sv
// Round-robin key dispatcher feeding a bank of RC4 decrypt cores.
// Optional per-core watchdog: define KEY_SEARCH_WATCHDOG_EN.
module key_search_scheduler #(
  parameter int          NUM_CORES      = 4,
  parameter logic [23:0] KEY_LIMIT      = 24'h400000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [24*NUM_CORES-1:0] core_key,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES-1:0]    core_found,
  output logic [NUM_CORES-1:0]    core_abort,
  output logic                    busy,
  output logic                    success,
  output logic                    total_failure,
  output logic [23:0]             found_key,
  output logic [9:0]              LEDR
);
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {IDLE, DISPATCH, DRAIN, SUCCESS, FAILURE} state_t;

  state_t                  state_reg;
  logic [23:0]             next_key_reg;
  logic [PTR_W-1:0]        rr_ptr_reg;
  logic [NUM_CORES-1:0]    core_busy_reg;
  logic [NUM_CORES-1:0]    core_start_reg;
  logic [NUM_CORES-1:0]    core_abort_reg;
  logic [24*NUM_CORES-1:0] core_key_reg;
  logic                    success_reg;
  logic                    failure_reg;
  logic                    wd_event_reg;
  logic [23:0]             found_key_reg;
  logic [2:0]              status_reg;

  logic                 run;
  logic [NUM_CORES-1:0] done_valid;
  logic [NUM_CORES-1:0] found_vec;
  logic [NUM_CORES-1:0] timeout_vec;
  logic [NUM_CORES-1:0] retire_vec;
  logic                 found_any;
  logic [PTR_W-1:0]     win_idx;
  logic                 idle_hit;
  logic [PTR_W-1:0]     launch_idx;
  logic [PTR_W-1:0]     cand_idx;
  logic                 launch_go;

  always_comb begin
    run        = (state_reg == DISPATCH) || (state_reg == DRAIN);
    done_valid = run ? (core_done & core_busy_reg) : '0;
    found_vec  = done_valid & core_found;
    found_any  = |found_vec;
    // Scan downwards so the lowest finding index is the last one written.
    win_idx    = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (found_vec[i]) win_idx = PTR_W'(i);
    end
    idle_hit   = 1'b0;
    launch_idx = '0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_idx = PTR_W'((int'(rr_ptr_reg) + k) % NUM_CORES);
      if (!idle_hit && !core_busy_reg[cand_idx]) begin
        idle_hit   = 1'b1;
        launch_idx = cand_idx;
      end
    end
    // A find in this cycle suppresses any launch.
    launch_go = (state_reg == DISPATCH) && !found_any &&
                (next_key_reg != KEY_LIMIT) && idle_hit;
  end

`ifdef KEY_SEARCH_WATCHDOG_EN
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_wd
    logic [19:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_reg <= '0;
      end else if (launch_go && (launch_idx == PTR_W'(gi))) begin
        cnt_reg <= '0;
      end else if (run && core_busy_reg[gi]) begin
        cnt_reg <= cnt_reg + 20'd1;
      end
    end

    // A genuine done in the same cycle beats the timeout.
    assign timeout_vec[gi] = run && core_busy_reg[gi] && !done_valid[gi] &&
                             ((cnt_reg + 20'd1) == TIMEOUT_CYCLES);
  end
`else
  assign timeout_vec = '0;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign retire_vec = done_valid | timeout_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      next_key_reg   <= '0;
      rr_ptr_reg     <= '0;
      core_busy_reg  <= '0;
      core_start_reg <= '0;
      core_abort_reg <= '0;
      core_key_reg   <= '0;
      success_reg    <= 1'b0;
      failure_reg    <= 1'b0;
      wd_event_reg   <= 1'b0;
      found_key_reg  <= '0;
      status_reg     <= '0;
    end else begin
      core_start_reg <= '0;
      core_abort_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= DISPATCH;
            next_key_reg  <= '0;
            core_busy_reg <= '0;
            success_reg   <= 1'b0;
            failure_reg   <= 1'b0;
            found_key_reg <= '0;
            status_reg    <= '0;
          end
        end
        DISPATCH, DRAIN: begin
          core_busy_reg  <= core_busy_reg & ~retire_vec;
          core_abort_reg <= timeout_vec;
          if (|timeout_vec) wd_event_reg <= 1'b1;
          if (found_any) begin
            state_reg      <= SUCCESS;
            success_reg    <= 1'b1;
            status_reg     <= 3'd3;
            found_key_reg  <= core_key_reg[24*int'(win_idx) +: 24];
            core_abort_reg <= core_busy_reg & ~done_valid;
            core_busy_reg  <= '0;
          end else if (state_reg == DISPATCH) begin
            if (launch_go) begin
              core_start_reg[launch_idx]               <= 1'b1;
              core_key_reg[24*int'(launch_idx) +: 24] <= next_key_reg;
              core_busy_reg[launch_idx]                <= 1'b1;
              next_key_reg <= next_key_reg + 24'd1;
              rr_ptr_reg   <= (int'(launch_idx) == NUM_CORES - 1) ? '0
                                                                  : launch_idx + PTR_W'(1);
              if ((next_key_reg + 24'd1) == KEY_LIMIT) state_reg <= DRAIN;
            end else if (next_key_reg == KEY_LIMIT) begin
              state_reg <= DRAIN;
            end
          end else if (~|(core_busy_reg & ~retire_vec)) begin
            state_reg   <= FAILURE;
            failure_reg <= 1'b1;
            status_reg  <= 3'd4;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_start    = core_start_reg;
  assign core_key      = core_key_reg;
  assign core_abort    = core_abort_reg;
  assign busy          = run;
  assign success       = success_reg;
  assign total_failure = failure_reg;
  assign found_key     = found_key_reg;
  assign LEDR          = {wd_event_reg, 6'b0, status_reg};
endmodule

// File: tb/tb_key_search_scheduler.sv
// Bench for key_search_scheduler: behavioural cores plus a launch scoreboard.
module tb_key_search_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           start;
  logic [N-1:0]   core_start;
  logic [24*N-1:0] core_key;
  logic [N-1:0]   core_done;
  logic [N-1:0]   core_found;
  logic [N-1:0]   core_abort;
  logic           busy;
  logic           success;
  logic           total_failure;
  logic [23:0]    found_key;
  logic [9:0]     LEDR;

  key_search_scheduler #(
    .NUM_CORES(N),
    .KEY_LIMIT(24'd8),
    .TIMEOUT_CYCLES(20'd50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .core_start(core_start),
    .core_key(core_key),
    .core_done(core_done),
    .core_found(core_found),
    .core_abort(core_abort),
    .busy(busy),
    .success(success),
    .total_failure(total_failure),
    .found_key(found_key),
    .LEDR(LEDR)
  );

  typedef struct {
    int          core;
    logic [23:0] key;
  } launch_t;

  int          n_tests = 0;
  int          n_fail = 0;
  int          step_no = 0;
  int          lat [N];
  int          cnt [N];
  logic [23:0] held_key [N];
  logic [23:0] find_keys [$];
  launch_t     exp_q [$];
  int          launch_steps [$];
  int          dones = 0;
  int          spur_after_key = -1;
  int          spur_core = -1;
  bit          check_launch = 1'b0;

  function automatic bit key_is_find(logic [23:0] k);
    foreach (find_keys[j]) if (find_keys[j] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_model();
    core_done  = '0;
    core_found = '0;
    for (int i = 0; i < N; i++) begin
      cnt[i]      = -1;
      held_key[i] = '0;
    end
    exp_q.delete();
    launch_steps.delete();
    find_keys.delete();
    dones          = 0;
    spur_after_key = -1;
    spur_core      = -1;
  endtask

  // One clock: sample just after the edge, run the core models, score launches.
  task automatic step();
    int      nstart;
    launch_t e;
    @(posedge clk);
    #1;
    step_no++;
    core_done  = '0;
    core_found = '0;
    if (spur_core >= 0) begin
      core_done[spur_core]  = 1'b1;
      core_found[spur_core] = 1'b1;
      spur_core = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (core_abort[i]) begin
        cnt[i] = -1;
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          cnt[i]        = -1;
          core_done[i]  = 1'b1;
          core_found[i] = key_is_find(held_key[i]);
          dones++;
          if (int'(held_key[i]) == spur_after_key) spur_core = i;
        end
      end
    end
    nstart = 0;
    for (int i = 0; i < N; i++) begin
      if (core_start[i]) begin
        nstart++;
        held_key[i] = core_key[24*i +: 24];
        cnt[i]      = lat[i];
        launch_steps.push_back(step_no);
        $display("[TB] step %0d launch core %0d key %06h", step_no, i, held_key[i]);
        if (check_launch) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL launch_unexpected: got core %0d key %06h, required no launch", i, held_key[i]);
          end else begin
            e = exp_q.pop_front();
            if (e.core != i || held_key[i] !== e.key) begin
              n_fail++;
              $display("FAIL launch_order: got core %0d key %06h, required core %0d key %06h",
                       i, held_key[i], e.core, e.key);
            end
          end
        end
      end
    end
    if (nstart > 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL launch_onehot: got core_start %b, required at most one bit", core_start);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    start = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic push_launch(int core, int key);
    launch_t e;
    e.core = core;
    e.key  = 24'(key);
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({core_start, core_key, core_abort, busy, success, total_failure, found_key, LEDR} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required all zero",
               {core_start, core_key, core_abort, busy, success, total_failure, found_key, LEDR});
    end
    reset = 1'b1;
    check_launch = 1'b1;
    repeat (3) step();
    n_tests++;
    if (busy !== 1'b0 || LEDR !== 10'd0 || success !== 1'b0 || total_failure !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy %b LEDR %h success %b failure %b, required 0 0 0 0",
               busy, LEDR, success, total_failure);
    end
  endtask

  task automatic test_round_robin_limit();
    int guard;
    reset_dut();
    foreach (lat[i]) lat[i] = 10;
    check_launch   = 1'b1;
    spur_after_key = 4;
    for (int k = 0; k < 8; k++) push_launch(k % N, k);
    pulse_start();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    guard = 0;
    while (dones < 8 && guard < 300) begin
      step();
      guard++;
    end
    n_tests++;
    if (dones < 8) begin
      n_fail++;
      $display("FAIL limit_timeout: got %0d dones, required 8", dones);
    end
    n_tests++;
    if (total_failure !== 1'b0) begin
      n_fail++;
      $display("FAIL failure_early: got %b at last done, required 0", total_failure);
    end
    step();
    n_tests++;
    if (total_failure !== 1'b1 || LEDR !== 10'd4 || success !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL exhausted: got failure %b LEDR %0d success %b busy %b, required 1 4 0 0",
               total_failure, LEDR, success, busy);
    end
    n_tests++;
    if (launch_steps.size() < 4 || launch_steps[1] - launch_steps[0] != 1 ||
        launch_steps[2] - launch_steps[1] != 1 || launch_steps[3] - launch_steps[2] != 1) begin
      n_fail++;
      $display("FAIL first_four_consecutive: got %0d launches with uneven spacing, required 1-cycle spacing",
               launch_steps.size());
    end
    repeat (20) step();
    n_tests++;
    if (launch_steps.size() != 8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL launch_count: got %0d launches (%0d pending), required 8 (0 pending)",
               launch_steps.size(), exp_q.size());
    end
  endtask

  task automatic test_find_with_aborts();
    int guard;
    int abort_cycles;
    reset_dut();
    lat = '{60, 60, 10, 60};
    find_keys.push_back(24'h000006);
    check_launch = 1'b1;
    push_launch(0, 0); push_launch(1, 1); push_launch(2, 2); push_launch(3, 3);
    push_launch(2, 4); push_launch(2, 5); push_launch(2, 6);
    pulse_start();
    guard = 0;
    while (success !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    n_tests++;
    if (success !== 1'b1) begin
      n_fail++;
      $display("FAIL find_timeout: got success %b, required 1", success);
    end
    n_tests++;
    if (found_key !== 24'h000006 || LEDR !== 10'd3 || busy !== 1'b0 || total_failure !== 1'b0) begin
      n_fail++;
      $display("FAIL find_result: got key %06h LEDR %0d busy %b failure %b, required 000006 3 0 0",
               found_key, LEDR, busy, total_failure);
    end
    n_tests++;
    if (core_abort !== 4'b1011) begin
      n_fail++;
      $display("FAIL find_abort: got %b, required 1011", core_abort);
    end
    abort_cycles = (core_abort != '0) ? 1 : 0;
    repeat (5) begin
      step();
      if (core_abort != '0) abort_cycles++;
    end
    n_tests++;
    if (abort_cycles != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_once: got %0d abort cycles (%0d launches pending), required 1 (0)",
               abort_cycles, exp_q.size());
    end
    pulse_start();
    repeat (5) step();
    n_tests++;
    if (success !== 1'b1 || found_key !== 24'h000006 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL success_terminal: got success %b key %06h busy %b, required 1 000006 0",
               success, found_key, busy);
    end
  endtask

  task automatic test_simultaneous_find();
    int guard;
    reset_dut();
    lat = '{40, 12, 40, 10};
    find_keys.push_back(24'h000001);
    find_keys.push_back(24'h000003);
    check_launch = 1'b1;
    push_launch(0, 0); push_launch(1, 1); push_launch(2, 2); push_launch(3, 3);
    pulse_start();
    guard = 0;
    while (success !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    n_tests++;
    if (success !== 1'b1 || found_key !== 24'h000001) begin
      n_fail++;
      $display("FAIL tie_winner: got success %b key %06h, required 1 000001", success, found_key);
    end
    n_tests++;
    if (core_abort !== 4'b0101) begin
      n_fail++;
      $display("FAIL tie_abort: got %b, required 0101", core_abort);
    end
  endtask

  task automatic test_reset_mid_search();
    int guard;
    reset_dut();
    foreach (lat[i]) lat[i] = 40;
    check_launch = 1'b1;
    push_launch(0, 0); push_launch(1, 1); push_launch(2, 2);
    pulse_start();
    repeat (3) step();
    n_tests++;
    if (busy !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pre_reset_search: got busy %b pending %0d, required 1 0", busy, exp_q.size());
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({core_start, core_key, core_abort, busy, success, total_failure, found_key, LEDR} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h, required all zero",
               {core_start, core_key, core_abort, busy, success, total_failure, found_key, LEDR});
    end
    @(posedge clk);
    #1;
    n_tests++;
    if ({core_start, core_key, core_abort, busy, LEDR} !== '0) begin
      n_fail++;
      $display("FAIL held_reset_outputs: got %h, required all zero",
               {core_start, core_key, core_abort, busy, LEDR});
    end
    clear_model();
    reset = 1'b1;
    push_launch(0, 0);
    pulse_start();
    guard = 0;
    while (launch_steps.size() == 0 && guard < 10) begin
      step();
      guard++;
    end
    n_tests++;
    if (launch_steps.size() == 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_launch: got %0d launches, required key 000000 on core 0", launch_steps.size());
    end
  endtask

`ifdef KEY_SEARCH_WATCHDOG_EN
  task automatic test_watchdog();
    int guard;
    int s0;
    int nlaunch;
    reset_dut();
    lat = '{0, 30, 30, 30};
    check_launch = 1'b0;
    pulse_start();
    guard = 0;
    while (launch_steps.size() == 0 && guard < 10) begin
      step();
      guard++;
    end
    s0 = (launch_steps.size() > 0) ? launch_steps[0] : step_no;
    guard = 0;
    while (core_abort[0] !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    n_tests++;
    if (core_abort[0] !== 1'b1 || step_no - s0 != 50) begin
      n_fail++;
      $display("FAIL wd_abort_time: got abort %b after %0d cycles, required 1 after 50",
               core_abort[0], step_no - s0);
    end
    n_tests++;
    if (LEDR[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_led: got LEDR[9] %b, required 1", LEDR[9]);
    end
    nlaunch = launch_steps.size();
    guard = 0;
    while (launch_steps.size() == nlaunch && guard < 20) begin
      step();
      guard++;
    end
    n_tests++;
    if (launch_steps.size() == nlaunch || core_start[0] !== 1'b1 || held_key[0] !== 24'd7) begin
      n_fail++;
      $display("FAIL wd_continue: got core_start %b key %06h, required core 0 key 000007",
               core_start, held_key[0]);
    end
    guard = 0;
    while (total_failure !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    n_tests++;
    if (total_failure !== 1'b1 || success !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_finish: got failure %b success %b, required 1 0", total_failure, success);
    end
  endtask
`endif

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    core_done  = '0;
    core_found = '0;
    foreach (lat[i]) lat[i] = 10;
    test_reset();
    test_round_robin_limit();
    test_find_with_aborts();
    test_simultaneous_find();
    test_reset_mid_search();
`ifdef KEY_SEARCH_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end
endmodule
